// File: rtl/video_mode_sched_if.sv
// video_mode_sched_if: host mode-change handshake (four-phase level).
// master drives req/mode and reads ack; slave is the scheduler side.
interface video_mode_sched_if;
  logic       host_req;
  logic [7:0] host_mode;
  logic       host_ack;

  modport master (
    output host_req,
    output host_mode,
    input  host_ack
  );

  modport slave (
    input  host_req,
    input  host_mode,
    output host_ack
  );
endinterface

// File: rtl/video_mode_sched.sv
// video_mode_sched: commits the 8-bit image_mode word only at vsync fall.
// Ports: clock/reset_n, vs_i, host handshake (if), auto_* alternation
//   controls, image_mode_o/mode_update_o/commit_src_o/busy_o/frame_cnt_o.
// Optional auto alternation: define VIDEO_MODE_SCHED_AUTO_EN.
module video_mode_sched #(
  parameter logic [7:0] RESET_MODE = 8'h00,
  parameter int         CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             vs_i,
  video_mode_sched_if.slave host,
  input  logic             auto_en_i,
  input  logic [7:0]       auto_period_i,
  input  logic [7:0]       auto_mode_a_i,
  input  logic [7:0]       auto_mode_b_i,
  output logic [7:0]       image_mode_o,
  output logic             mode_update_o,
  output logic             commit_src_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] frame_cnt_o
);

  typedef enum logic [1:0] {
    IDLE, HOST_PEND, AUTO_PEND, HOST_ACK
  } state_e;

  state_e           state_q, state_d;
  logic             vs_d0_q;
  logic             vs_fall;
  logic [7:0]       pend_mode_q, pend_mode_d;
  logic [7:0]       image_mode_q, image_mode_d;
  logic             mode_update_q, mode_update_d;
  logic             commit_src_q, commit_src_d;
  logic             host_ack_q, host_ack_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             auto_go;
  logic [7:0]       auto_val;

  assign vs_fall = vs_d0_q & ~vs_i;

`ifdef VIDEO_MODE_SCHED_AUTO_EN
  logic [7:0] auto_cnt_q, auto_cnt_d;
  logic [7:0] auto_per;
  logic       auto_pend_q, auto_pend_d;
  logic       alt_sel_q, alt_sel_d;
  logic       auto_commit;

  assign auto_commit = (state_q == AUTO_PEND) & vs_fall;
  assign auto_go     = auto_pend_q;
  assign auto_val    = alt_sel_q ? auto_mode_b_i
                                 : auto_mode_a_i;
  assign auto_per    = (auto_period_i == 8'd0) ? 8'd1
                                               : auto_period_i;

  // The committing edge restarts the count and is itself the first
  // frame of the new period, so period N yields a commit every N frames.
  always_comb begin
    auto_cnt_d  = auto_cnt_q;
    auto_pend_d = auto_pend_q;
    alt_sel_d   = alt_sel_q ^ auto_commit;
    if (auto_commit) begin
      auto_cnt_d  = 8'd0;
      auto_pend_d = 1'b0;
    end
    if (!auto_en_i) begin
      auto_cnt_d  = 8'd0;
      auto_pend_d = 1'b0;
    end else if (vs_fall && !auto_pend_d) begin
      if ({1'b0, auto_cnt_d} + 9'd1 >= {1'b0, auto_per})
        auto_pend_d = 1'b1;
      else
        auto_cnt_d = auto_cnt_d + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      auto_cnt_q  <= 8'd0;
      auto_pend_q <= 1'b0;
      alt_sel_q   <= 1'b0;
    end else begin
      auto_cnt_q  <= auto_cnt_d;
      auto_pend_q <= auto_pend_d;
      alt_sel_q   <= alt_sel_d;
    end
  end
`else
  logic unused_auto;
  assign unused_auto = ^{auto_en_i, auto_period_i,
                         auto_mode_a_i, auto_mode_b_i};
  assign auto_go     = 1'b0;
  assign auto_val    = 8'h00;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (host.host_req) state_d = HOST_PEND;
        else if (auto_go)  state_d = AUTO_PEND;
      end
      HOST_PEND: if (vs_fall)         state_d = HOST_ACK;
      AUTO_PEND: if (vs_fall)         state_d = IDLE;
      HOST_ACK:  if (!host.host_req)  state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  always_comb begin
    pend_mode_d   = pend_mode_q;
    image_mode_d  = image_mode_q;
    mode_update_d = 1'b0;
    commit_src_d  = commit_src_q;
    host_ack_d    = host_ack_q;
    frame_cnt_d   = frame_cnt_q + {{(CNT_W-1){1'b0}}, vs_fall};
    busy_d        = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (host.host_req) pend_mode_d = host.host_mode;
        else if (auto_go)  pend_mode_d = auto_val;
      end
      HOST_PEND: begin
        if (vs_fall) begin
          image_mode_d  = pend_mode_q;
          mode_update_d = 1'b1;
          commit_src_d  = 1'b0;
          host_ack_d    = 1'b1;
        end
      end
      AUTO_PEND: begin
        if (vs_fall) begin
          image_mode_d  = pend_mode_q;
          mode_update_d = 1'b1;
          commit_src_d  = 1'b1;
        end
      end
      HOST_ACK: if (!host.host_req) host_ack_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vs_d0_q       <= 1'b0;
      pend_mode_q   <= 8'h00;
      image_mode_q  <= RESET_MODE;
      mode_update_q <= 1'b0;
      commit_src_q  <= 1'b0;
      host_ack_q    <= 1'b0;
      busy_q        <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      vs_d0_q       <= vs_i;
      pend_mode_q   <= pend_mode_d;
      image_mode_q  <= image_mode_d;
      mode_update_q <= mode_update_d;
      commit_src_q  <= commit_src_d;
      host_ack_q    <= host_ack_d;
      busy_q        <= busy_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign image_mode_o  = image_mode_q;
  assign mode_update_o = mode_update_q;
`ifdef VIDEO_MODE_SCHED_AUTO_EN
  assign commit_src_o  = commit_src_q;
`else
  logic unused_src;
  assign unused_src    = commit_src_q;
  assign commit_src_o  = 1'b0;
`endif
  assign busy_o        = busy_q;
  assign frame_cnt_o   = frame_cnt_q;
  assign host.host_ack = host_ack_q;

endmodule
